// File: rtl/usb_txn_ctrl_if.sv
// Bundle of host-command and datapath packet signals around the USB transaction sequencer.
// The slave modport is the sequencer's view; master is the surrounding host/datapath.
interface usb_txn_ctrl_if;
  logic        txn_start;
  logic        txn_is_in;
  logic [6:0]  txn_addr;
  logic [3:0]  txn_endp;
  logic [63:0] txn_data_out;
  logic [63:0] txn_data_in;
  logic        txn_busy;
  logic        txn_done;
  logic        txn_ok;
  logic [98:0] pkt_in;
  logic        pkt_in_avail;
  logic        encoder_ready;
  logic        nrzi_avail;
  logic        re;
  logic [98:0] pkt_out;
  logic        pkt_out_avail;
  logic        data_good;
  logic        decoder_ready;

  modport slave (
    input  txn_start, txn_is_in, txn_addr, txn_endp, txn_data_out,
    output txn_data_in, txn_busy, txn_done, txn_ok,
    output pkt_in, pkt_in_avail, re,
    input  encoder_ready, nrzi_avail, pkt_out, pkt_out_avail, data_good, decoder_ready
  );

  modport master (
    output txn_start, txn_is_in, txn_addr, txn_endp, txn_data_out,
    input  txn_data_in, txn_busy, txn_done, txn_ok,
    input  pkt_in, pkt_in_avail, re,
    output encoder_ready, nrzi_avail, pkt_out, pkt_out_avail, data_good, decoder_ready
  );
endinterface

// File: rtl/usb_txn_ctrl.sv
// Host-side USB transaction sequencer: token, data, handshake with receive timeout and retries.
// All outputs are registered; the comb block computes next values for every register.
module usb_txn_ctrl #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 8
) (
  input logic           clk,
  input logic           rst_b,
  usb_txn_ctrl_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0] MAX_ATT  = 4'(MAX_RETRY);
  localparam logic [3:0] PID_OUT  = 4'b0001;
  localparam logic [3:0] PID_IN   = 4'b1001;
  localparam logic [3:0] PID_D0   = 4'b0011;
  localparam logic [3:0] PID_D1   = 4'b1011;
  localparam logic [3:0] PID_ACK  = 4'b0010;

  typedef enum logic [3:0] {
    S_IDLE, S_TOKEN, S_TX_WAIT, S_DATA_TX, S_RX_HS, S_RX_DATA, S_HS_TX, S_FAIL, S_DONE
  } state_t;

  typedef enum logic [1:0] {K_TOKEN, K_DATA, K_ACK} kind_t;

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic          is_in_q, is_in_d;
  logic [6:0]    addr_q, addr_d;
  logic [3:0]    endp_q, endp_d;
  logic [63:0]   data_q, data_d;
  logic [3:0]    attempt_q, attempt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          seen_q, seen_d;
  logic [98:0]   pkt_in_q, pkt_in_d;
  logic          avail_q, avail_d;
  logic          re_q, re_d;
  logic [63:0]   data_in_q, data_in_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ok_q, ok_d;
  logic [7:0]    rx_pid;
  logic          unused_inputs;

  assign rx_pid        = bus.pkt_out[7:0];
  assign unused_inputs = ^{bus.decoder_ready, bus.pkt_out[98:72]};

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    is_in_d   = is_in_q;
    addr_d    = addr_q;
    endp_d    = endp_q;
    data_d    = data_q;
    attempt_d = attempt_q;
    tmo_d     = tmo_q;
    seen_d    = seen_q;
    pkt_in_d  = pkt_in_q;
    avail_d   = 1'b0;
    re_d      = re_q;
    data_in_d = data_in_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ok_d      = ok_q;
    case (state_q)
      S_IDLE: if (bus.txn_start) begin
        is_in_d   = bus.txn_is_in;
        addr_d    = bus.txn_addr;
        endp_d    = bus.txn_endp;
        data_d    = bus.txn_data_out;
        attempt_d = 4'd1;
        busy_d    = 1'b1;
        ok_d      = 1'b0;
        state_d   = S_TOKEN;
      end
      S_TOKEN: if (bus.encoder_ready) begin
        pkt_in_d = {80'd0, endp_q, addr_q, pid_byte(is_in_q ? PID_IN : PID_OUT)};
        avail_d  = 1'b1;
        kind_d   = K_TOKEN;
        seen_d   = 1'b0;
        state_d  = S_TX_WAIT;
      end
      // Leave only after the line has been seen busy and then idle again.
      S_TX_WAIT: begin
        if (bus.nrzi_avail) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          case (kind_q)
            K_TOKEN: begin
              if (is_in_q) begin
                state_d = S_RX_DATA;
                re_d    = 1'b1;
                tmo_d   = '0;
              end else begin
                state_d = S_DATA_TX;
              end
            end
            K_DATA: begin
              state_d = S_RX_HS;
              re_d    = 1'b1;
              tmo_d   = '0;
            end
            default: begin
              state_d = S_DONE;
              done_d  = 1'b1;
              ok_d    = 1'b1;
            end
          endcase
        end
      end
      S_DATA_TX: if (bus.encoder_ready) begin
        pkt_in_d = {27'd0, data_q, pid_byte(PID_D0)};
        avail_d  = 1'b1;
        kind_d   = K_DATA;
        seen_d   = 1'b0;
        state_d  = S_TX_WAIT;
      end
      // A packet on the final timeout cycle wins over the timeout.
      S_RX_HS: begin
        if (bus.pkt_out_avail) begin
          re_d = 1'b0;
          if (bus.data_good && rx_pid == pid_byte(PID_ACK)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            ok_d    = 1'b1;
          end else begin
            state_d = S_FAIL;
          end
        end else if (tmo_q == TMO_LAST) begin
          re_d    = 1'b0;
          state_d = S_FAIL;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RX_DATA: begin
        if (bus.pkt_out_avail) begin
          re_d = 1'b0;
          if (bus.data_good && (rx_pid == pid_byte(PID_D0) || rx_pid == pid_byte(PID_D1))) begin
            data_in_d = bus.pkt_out[71:8];
            state_d   = S_HS_TX;
          end else begin
            state_d = S_FAIL;
          end
        end else if (tmo_q == TMO_LAST) begin
          re_d    = 1'b0;
          state_d = S_FAIL;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_HS_TX: if (bus.encoder_ready) begin
        pkt_in_d = {91'd0, pid_byte(PID_ACK)};
        avail_d  = 1'b1;
        kind_d   = K_ACK;
        seen_d   = 1'b0;
        state_d  = S_TX_WAIT;
      end
      S_FAIL: begin
        if (attempt_q == MAX_ATT) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          ok_d    = 1'b0;
        end else begin
          attempt_d = attempt_q + 4'd1;
          state_d   = S_TOKEN;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= S_IDLE;
      kind_q    <= K_TOKEN;
      is_in_q   <= 1'b0;
      addr_q    <= '0;
      endp_q    <= '0;
      data_q    <= '0;
      attempt_q <= '0;
      tmo_q     <= '0;
      seen_q    <= 1'b0;
      pkt_in_q  <= '0;
      avail_q   <= 1'b0;
      re_q      <= 1'b0;
      data_in_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      is_in_q   <= is_in_d;
      addr_q    <= addr_d;
      endp_q    <= endp_d;
      data_q    <= data_d;
      attempt_q <= attempt_d;
      tmo_q     <= tmo_d;
      seen_q    <= seen_d;
      pkt_in_q  <= pkt_in_d;
      avail_q   <= avail_d;
      re_q      <= re_d;
      data_in_q <= data_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
    end
  end

  assign bus.pkt_in       = pkt_in_q;
  assign bus.pkt_in_avail = avail_q;
  assign bus.re           = re_q;
  assign bus.txn_data_in  = data_in_q;
  assign bus.txn_busy     = busy_q;
  assign bus.txn_done     = done_q;
  assign bus.txn_ok       = ok_q;

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Directed bench for usb_txn_ctrl: behavioural encoder/line and device responder around the DUT.
module tb_usb_txn_ctrl;

  typedef struct {
    logic [98:0] pkt;
    logic        good;
  } resp_t;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  usb_txn_ctrl_if bus();

  usb_txn_ctrl #(.TIMEOUT(255), .MAX_RETRY(8)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int strobes = 0;
  int done_cnt = 0;
  int overlap = 0;
  int resp_delay = 3;
  int nrzi_left = 0;
  int rx_cyc = 0;
  logic [98:0] tx_log[$];
  int re_lens[$];
  resp_t resp_q[$];

  function automatic logic [98:0] mkToken(input logic [7:0] pb, input logic [6:0] a, input logic [3:0] e);
    return {80'd0, e, a, pb};
  endfunction

  function automatic logic [98:0] mkData(input logic [7:0] pb, input logic [63:0] d);
    return {27'd0, d, pb};
  endfunction

  function automatic logic [98:0] mkHs(input logic [7:0] pb);
    return {91'd0, pb};
  endfunction

  function automatic logic [98:0] getLog(input int i);
    if (i < tx_log.size()) return tx_log[i];
    return '1;
  endfunction

  function automatic int countByte(input logic [7:0] b);
    int n = 0;
    foreach (tx_log[i]) if (tx_log[i][7:0] == b) n++;
    return n;
  endfunction

  function automatic int count255();
    int n = 0;
    foreach (re_lens[i]) if (re_lens[i] == 255) n++;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [98:0] got, input logic [98:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic is_in, input logic [6:0] a, input logic [3:0] e,
                               input logic [63:0] d);
    strobes = 0;
    tx_log.delete();
    re_lens.delete();
    @(negedge clk);
    bus.txn_start    = 1'b1;
    bus.txn_is_in    = is_in;
    bus.txn_addr     = a;
    bus.txn_endp     = e;
    bus.txn_data_out = d;
    @(negedge clk);
    bus.txn_start = 1'b0;
    checkOutput("busy_after_start", 99'(bus.txn_busy), 99'(1));
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (!bus.txn_done && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done"}, 99'(bus.txn_done), 99'(1));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_pkt_in"}, bus.pkt_in, 99'(0));
    checkOutput({tag, "_avail"}, 99'(bus.pkt_in_avail), 99'(0));
    checkOutput({tag, "_re"}, 99'(bus.re), 99'(0));
    checkOutput({tag, "_data_in"}, 99'(bus.txn_data_in), 99'(0));
    checkOutput({tag, "_busy"}, 99'(bus.txn_busy), 99'(0));
    checkOutput({tag, "_done"}, 99'(bus.txn_done), 99'(0));
    checkOutput({tag, "_ok"}, 99'(bus.txn_ok), 99'(0));
  endtask

  // Encoder/line model: each send strobe keeps the line busy for four cycles.
  initial forever begin
    @(negedge clk);
    if (bus.pkt_in_avail) begin
      strobes++;
      tx_log.push_back(bus.pkt_in);
      nrzi_left = 4;
    end
    if (nrzi_left > 0) begin
      bus.nrzi_avail = 1'b1;
      nrzi_left--;
    end else begin
      bus.nrzi_avail = 1'b0;
    end
  end

  // Device model: answers on the resp_delay-th cycle of re, and records how long re stayed high.
  initial begin : device
    resp_t r;
    forever begin
      @(negedge clk);
      bus.pkt_out_avail = 1'b0;
      bus.data_good     = 1'b0;
      bus.pkt_out       = '0;
      if (bus.re) begin
        rx_cyc++;
        if (rx_cyc == resp_delay && resp_q.size() > 0) begin
          r = resp_q.pop_front();
          bus.pkt_out       = r.pkt;
          bus.data_good     = r.good;
          bus.pkt_out_avail = 1'b1;
        end
      end else if (rx_cyc != 0) begin
        re_lens.push_back(rx_cyc);
        rx_cyc = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.txn_done) done_cnt++;
    if (bus.re && bus.pkt_in_avail) overlap++;
  end

  initial begin
    int d0;
    int n;
    bus.txn_start     = 1'b0;
    bus.txn_is_in     = 1'b0;
    bus.txn_addr      = '0;
    bus.txn_endp      = '0;
    bus.txn_data_out  = '0;
    bus.encoder_ready = 1'b1;
    bus.nrzi_avail    = 1'b0;
    bus.pkt_out       = '0;
    bus.pkt_out_avail = 1'b0;
    bus.data_good     = 1'b0;
    bus.decoder_ready = 1'b1;

    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_b = 1'b1;
    @(negedge clk);

    $display("[TB] OUT with ACK");
    resp_q.delete();
    resp_delay = 3;
    resp_q.push_back('{mkHs(8'hD2), 1'b1});
    applyStimulus(1'b0, 7'h05, 4'h1, 64'hDEAD_BEEF_0123_4567);
    waitDone("out_ack");
    checkOutput("out_ack_ok", 99'(bus.txn_ok), 99'(1));
    repeat (2) @(negedge clk);
    checkOutput("out_ack_strobes", 99'(strobes), 99'(2));
    checkOutput("out_ack_token", getLog(0), mkToken(8'hE1, 7'h05, 4'h1));
    checkOutput("out_ack_data", getLog(1), mkData(8'hC3, 64'hDEAD_BEEF_0123_4567));
    checkOutput("out_ack_re_len", 99'(re_lens.size() > 0 ? re_lens[0] : 0), 99'(3));
    checkOutput("out_ack_busy_low", 99'(bus.txn_busy), 99'(0));

    $display("[TB] OUT with NAK NAK ACK and an ignored start");
    resp_q.delete();
    resp_q.push_back('{mkHs(8'h5A), 1'b1});
    resp_q.push_back('{mkHs(8'h5A), 1'b1});
    resp_q.push_back('{mkHs(8'hD2), 1'b1});
    d0 = done_cnt;
    applyStimulus(1'b0, 7'h0A, 4'h3, 64'h1111_2222_3333_4444);
    @(negedge clk);
    bus.txn_start = 1'b1;
    bus.txn_is_in = 1'b1;
    @(negedge clk);
    bus.txn_start = 1'b0;
    waitDone("out_nak");
    checkOutput("out_nak_ok", 99'(bus.txn_ok), 99'(1));
    repeat (3) @(negedge clk);
    checkOutput("out_nak_strobes", 99'(strobes), 99'(6));
    checkOutput("out_nak_tokens", 99'(countByte(8'hE1)), 99'(3));
    checkOutput("out_nak_datas", 99'(countByte(8'hC3)), 99'(3));
    checkOutput("out_nak_done_cnt", 99'(done_cnt - d0), 99'(1));
    checkOutput("out_nak_idle", 99'(bus.txn_busy), 99'(0));

    $display("[TB] IN with DATA1");
    resp_q.delete();
    resp_q.push_back('{mkData(8'h4B, 64'h0011_2233_4455_6677), 1'b1});
    applyStimulus(1'b1, 7'h12, 4'h2, 64'h0);
    waitDone("in_d1");
    checkOutput("in_d1_ok", 99'(bus.txn_ok), 99'(1));
    checkOutput("in_d1_data", 99'(bus.txn_data_in), 99'(64'h0011_2233_4455_6677));
    repeat (2) @(negedge clk);
    checkOutput("in_d1_strobes", 99'(strobes), 99'(2));
    checkOutput("in_d1_token", getLog(0), mkToken(8'h69, 7'h12, 4'h2));
    checkOutput("in_d1_ack", getLog(1), mkHs(8'hD2));

    $display("[TB] IN with bad CRC on every attempt");
    resp_q.delete();
    for (int i = 0; i < 8; i++) resp_q.push_back('{mkData(8'hC3, 64'h0BAD), 1'b0});
    applyStimulus(1'b1, 7'h12, 4'h2, 64'h0);
    waitDone("in_bad");
    checkOutput("in_bad_ok", 99'(bus.txn_ok), 99'(0));
    repeat (2) @(negedge clk);
    checkOutput("in_bad_tokens", 99'(countByte(8'h69)), 99'(8));
    checkOutput("in_bad_no_ack", 99'(countByte(8'hD2)), 99'(0));
    checkOutput("in_bad_consumed", 99'(resp_q.size()), 99'(0));

    $display("[TB] OUT with no response");
    resp_q.delete();
    applyStimulus(1'b0, 7'h01, 4'h0, 64'h55);
    waitDone("out_tmo");
    checkOutput("out_tmo_ok", 99'(bus.txn_ok), 99'(0));
    repeat (2) @(negedge clk);
    checkOutput("out_tmo_attempts", 99'(re_lens.size()), 99'(8));
    checkOutput("out_tmo_re_255", 99'(count255()), 99'(8));
    checkOutput("out_tmo_strobes", 99'(strobes), 99'(16));

    $display("[TB] OUT with ACK on the timeout cycle");
    resp_q.delete();
    resp_delay = 255;
    resp_q.push_back('{mkHs(8'hD2), 1'b1});
    applyStimulus(1'b0, 7'h01, 4'h0, 64'h66);
    waitDone("out_edge");
    checkOutput("out_edge_ok", 99'(bus.txn_ok), 99'(1));
    repeat (2) @(negedge clk);
    checkOutput("out_edge_strobes", 99'(strobes), 99'(2));
    checkOutput("out_edge_re_len", 99'(re_lens.size() > 0 ? re_lens[0] : 0), 99'(255));
    resp_delay = 3;

    $display("[TB] reset during RX_DATA");
    resp_q.delete();
    applyStimulus(1'b1, 7'h33, 4'h3, 64'h0);
    n = 0;
    while (!bus.re && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_reached_rx", 99'(bus.re), 99'(1));
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    rst_b = 1'b0;
    #1;
    checkResetOutputs("rst_mid");
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rst_no_done", 99'(done_cnt - d0), 99'(0));
    checkOutput("rst_idle_busy", 99'(bus.txn_busy), 99'(0));

    resp_q.push_back('{mkData(8'hC3, 64'hCAFE_F00D_1234_5678), 1'b1});
    applyStimulus(1'b1, 7'h12, 4'h2, 64'h0);
    waitDone("after_rst");
    checkOutput("after_rst_ok", 99'(bus.txn_ok), 99'(1));
    checkOutput("after_rst_data", 99'(bus.txn_data_in), 99'(64'hCAFE_F00D_1234_5678));
    repeat (2) @(negedge clk);
    checkOutput("after_rst_strobes", 99'(strobes), 99'(2));
    checkOutput("re_avail_overlap", 99'(overlap), 99'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_txn_ctrl.md
# usb_txn_ctrl

Host-side transaction sequencer for the USB datapath. It accepts one OUT or IN transaction request from the host logic and sequences the datapath's packet interface through the transaction's packets: token, then data, then handshake. It also controls receive enable, enforces a response timeout, and retries failed attempts up to a fixed limit. It sits between the host command logic and the datapath, in the role of the protocol FSM.

## Interface
- TIMEOUT, 255: receive-wait limit in clk cycles per attempt.
- MAX_RETRY, 8: total attempts before a transaction fails (1..15).

- clk  in  1  system clock.
- rst_b  in  1  asynchronous, active-low reset.
- txn_start  in  1  request pulse; sampled only in IDLE.
- txn_is_in  in  1  1 = IN transaction, 0 = OUT transaction.
- txn_addr  in  7  device address.
- txn_endp  in  4  endpoint.
- txn_data_out  in  64  OUT payload.
- txn_data_in  out  64  IN payload, valid when txn_done=1 and txn_ok=1.
- txn_busy  out  1  high from accept through DONE.
- txn_done  out  1  one-cycle completion pulse.
- txn_ok  out  1  transaction result, valid with txn_done.
- pkt_in  out  99  packet to the encoder.
- pkt_in_avail  out  1  one-cycle send strobe.
- encoder_ready  in  1  encoder can accept a packet.
- nrzi_avail  in  1  line transmit in progress.
- re  out  1  receive enable to dpdm.
- pkt_out  in  99  decoded received packet.
- pkt_out_avail  in  1  one-cycle receive strobe.
- data_good  in  1  CRC check result, qualified by pkt_out_avail.
- decoder_ready  in  1  decoder idle; informational, not used for sequencing.

## Operation
- Packet layout (pkt_in and pkt_out):
  - [7:0] = {~pid, pid}.
  - Token packets: [14:8] = addr, [18:15] = endp.
  - Data packets: [71:8] = payload.
  - All unused bits are 0. CRC is inserted and checked by the datapath.
- PIDs:
  - OUT = 4'b0001, IN = 4'b1001.
  - DATA0 = 4'b0011, DATA1 = 4'b1011.
  - ACK = 4'b0010, NAK = 4'b1010.
  - The controller always transmits DATA0 and accepts DATA0 or DATA1 on receive.
- IDLE: on txn_start=1, latch txn_is_in, txn_addr, txn_endp and txn_data_out; clear attempt counter to 1; go to TOKEN.
- TOKEN: wait for encoder_ready=1, then drive the token packet (OUT or IN PID) with a pkt_in_avail pulse; go to TX_WAIT.
- TX_WAIT: wait until nrzi_avail has been sampled 1 and then sampled 0. The next state is chosen as follows:
  - After token, OUT transaction: go to DATA_TX.
  - After token, IN transaction: go to RX_DATA.
  - After data: go to RX_HS.
  - After ACK: go to DONE with ok=1.
- DATA_TX: wait for encoder_ready=1; send DATA0 carrying the latched payload; go to TX_WAIT.
- RX_HS (OUT transaction): re=1. On pkt_out_avail, classify the packet:
  - data_good=1 and PID=ACK: go to DONE with ok=1.
  - Any other packet (NAK, wrong PID, PID check-nibble mismatch, or data_good=0): FAIL.
  - No packet within the timeout window: FAIL.
- RX_DATA (IN transaction): re=1. On pkt_out_avail, classify the packet:
  - data_good=1 and PID is DATA0 or DATA1: latch [71:8] into txn_data_in, go to HS_TX.
  - Any other packet: FAIL.
  - No packet within the timeout window: FAIL.
- HS_TX: wait for encoder_ready=1; send ACK; go to TX_WAIT.
- FAIL: if attempt counter = MAX_RETRY, go to DONE with ok=0. Otherwise increment the counter and go to TOKEN.
- DONE: pulse txn_done for one cycle with txn_ok held; then go to IDLE.
- txn_start outside IDLE is ignored; the request must be re-issued after txn_done.
- Packets that arrive with pkt_out_avail outside RX states are ignored.

## Timing
- Reset values: all outputs are 0 (pkt_in, pkt_in_avail, re, txn_data_in, txn_busy, txn_done, txn_ok). State is IDLE; counters are 0.
- Assertion of rst_b=0 mid-transaction aborts immediately and returns to the reset values. No txn_done is issued.
- txn_busy goes high the cycle after txn_start is sampled.
- The first pkt_in_avail occurs ≥1 cycle later, as soon as encoder_ready=1.
- pkt_in is registered and held stable from the strobe cycle until the next packet is loaded.
- re is registered:
  - It rises on entry to RX_HS or RX_DATA.
  - It falls the cycle after the packet is accepted or the timeout expires.
  - It is never high in the same cycle as pkt_in_avail.
- Timeout counter:
  - Cleared on RX state entry.
  - Incremented each RX cycle.
  - The timeout fires when the count reaches TIMEOUT with no pkt_out_avail.
  - If pkt_out_avail arrives in that same cycle, the packet takes priority over the timeout.
- FAIL lasts exactly 1 cycle. DONE lasts exactly 1 cycle.

## Test plan
- OUT, addr 7'h05, endp 4'h1, data 64'hDEAD_BEEF_0123_4567:
  - Device replies ACK.
  - Required: pkt_in carries 8'hE1 token, then 8'hC3 DATA0 with the payload.
  - Required: txn_done with txn_ok=1; exactly 2 pkt_in_avail strobes.
- OUT where the device replies NAK, NAK, then ACK:
  - Required: 3 token strobes and txn_ok=1 after 6 total send strobes.
- IN, addr 7'h12:
  - Device returns DATA1 with payload 64'h0011_2233_4455_6677, data_good=1.
  - Required: ACK (8'hD2) sent; txn_data_in equals the payload; txn_ok=1.
- IN where every reply has data_good=0:
  - Required: no ACK is ever sent.
  - Required: txn_ok=0 after exactly MAX_RETRY=8 token strobes.
- OUT with no response (TIMEOUT=255):
  - Required: re is high for 255 cycles per attempt; txn_done with txn_ok=0 after 8 attempts.
  - Required: a pkt_out_avail ACK arriving on the timeout cycle is accepted instead.
- rst_b asserted during RX_DATA:
  - Required: outputs return to 0 and no txn_done is issued.
  - Required: a subsequent txn_start runs a clean transaction.
